// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter.
// The ME/WB writeback always owns the port. A divider result that collides
// with it is parked in a one-entry buffer and drained on the next free cycle.
// If the buffer stays blocked too long, a pipeline bubble is requested so the
// parked result can drain. A younger pipeline write to the same register
// kills the parked result instead of letting it overwrite newer data.
module wb_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_we_i,
  input  logic [4:0]  pipe_waddr_i,
  input  logic [31:0] pipe_wdata_i,
  input  logic        div_valid_i,
  input  logic [4:0]  div_waddr_i,
  input  logic [31:0] div_wdata_i,
  output logic        div_ready_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        stall_req_o,
  output logic        pend_o,
  output logic [4:0]  pend_waddr_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  // Counter value at which a still-blocked buffer escalates to a stall.
  localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_WAIT - 32'sd1);

  state_t             state_r;
  state_t             state_nx_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nx_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               buf_valid_r;
  logic [4:0]         buf_waddr_r;
  logic [31:0]        buf_wdata_r;
  logic               stall_r;

  logic               pipe_act_s;
  logic               div_acc_s;
  logic               load_s;
  logic               kill_s;
  logic               drain_s;

  // Writes to x0 are no-ops, so they never occupy the port.
  assign pipe_act_s = pipe_we_i && (pipe_waddr_i != 5'd0);
  // A result is only taken while the buffer is empty, so drain and accept never overlap.
  assign div_acc_s  = div_valid_i && !buf_valid_r;
  // Blocked, nonzero, accepted result gets parked.
  assign load_s     = div_acc_s && (div_waddr_i != 5'd0) && pipe_act_s;
  // Younger pipeline write to the parked register makes the parked value stale.
  assign kill_s     = buf_valid_r && pipe_act_s && (pipe_waddr_i == buf_waddr_r);
  assign drain_s    = buf_valid_r && !pipe_act_s;
  assign cnt_inc_s  = cnt_r + CNT_W'(1);

  assign div_ready_o  = !buf_valid_r;
  assign pend_o       = buf_valid_r;
  assign pend_waddr_o = buf_valid_r ? buf_waddr_r : 5'd0;
  assign stall_req_o  = stall_r;

  // Write-port mux: pipeline first, then buffered drain, then divider bypass.
  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = 5'd0;
    rf_wdata_o = 32'd0;
    if (pipe_act_s) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = pipe_waddr_i;
      rf_wdata_o = pipe_wdata_i;
    end else if (buf_valid_r) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = buf_waddr_r;
      rf_wdata_o = buf_wdata_r;
    end else if (div_valid_i && (div_waddr_i != 5'd0)) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = div_waddr_i;
      rf_wdata_o = div_wdata_i;
    end else begin
      rf_we_o    = 1'b0;
      rf_waddr_o = 5'd0;
      rf_wdata_o = 32'd0;
    end
  end

  // Next-state and wait-counter logic for the starvation FSM.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (load_s) begin
          cnt_nx_s   = {CNT_W{1'b0}};
          state_nx_s = (MAX_WAIT == 32'sd1) ? ST_FORCE : ST_PEND;
        end else begin
          cnt_nx_s   = {CNT_W{1'b0}};
          state_nx_s = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (kill_s || drain_s) begin
          cnt_nx_s   = {CNT_W{1'b0}};
          state_nx_s = ST_IDLE;
        end else if (pipe_act_s) begin
          cnt_nx_s   = cnt_inc_s;
          state_nx_s = (cnt_inc_s >= MAX_M1) ? ST_FORCE : ST_PEND;
        end else begin
          state_nx_s = ST_PEND;
        end
      end
      ST_FORCE: begin
        // Counter holds here so it can never wrap while waiting for the bubble.
        if (kill_s || drain_s) begin
          cnt_nx_s   = {CNT_W{1'b0}};
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_FORCE;
        end
      end
      default: begin
        cnt_nx_s   = {CNT_W{1'b0}};
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, wait counter and registered stall request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      stall_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      stall_r <= (state_nx_s == ST_FORCE);
    end
  end

  // One-entry holding buffer: load on blocked accept, clear on drain or kill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_r <= 1'b0;
      buf_waddr_r <= 5'd0;
      buf_wdata_r <= 32'd0;
    end else if (load_s) begin
      buf_valid_r <= 1'b1;
      buf_waddr_r <= div_waddr_i;
      buf_wdata_r <= div_wdata_i;
    end else if (kill_s || drain_s) begin
      buf_valid_r <= 1'b0;
      buf_waddr_r <= 5'd0;
      buf_wdata_r <= 32'd0;
    end else begin
      buf_valid_r <= buf_valid_r;
      buf_waddr_r <= buf_waddr_r;
      buf_wdata_r <= buf_wdata_r;
    end
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port between two requesters.
- Requester 1: the ME/WB pipeline writeback. It always has priority and is never delayed.
- Requester 2: the multi-cycle divider result, which arrives asynchronously to the pipeline flow.
- A one-entry holding buffer parks a blocked divider result, and a starvation counter forces a pipeline bubble so the buffer eventually drains.
- Sits between the ME/WB register outputs and the register file; pending-write status is exported to the hazard unit.

Parameters:
- MAX_WAIT, default 4: number of blocked cycles a buffered divider result tolerates before a stall is requested. Legal range is 1..15.
- CNT_W, default 4: width of the wait counter. Must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- pipe_we_i  input  1  write enable from ME/WB
- pipe_waddr_i  input  5  destination register from ME/WB
- pipe_wdata_i  input  32  writeback data from ME/WB
- div_valid_i  input  1  divider result valid
- div_waddr_i  input  5  divider destination register
- div_wdata_i  input  32  divider result
- div_ready_o  output  1  arbiter can accept a divider result this cycle
- rf_we_o  output  1  register-file write enable
- rf_waddr_o  output  5  register-file write address
- rf_wdata_o  output  32  register-file write data
- stall_req_o  output  1  request to the pipeline controller to insert a bubble into ME/WB
- pend_o  output  1  buffered divider write outstanding
- pend_waddr_o  output  5  destination register of the buffered write (0 when pend_o=0)

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: buffer invalid, buf_waddr=0, buf_wdata=0, wait counter=0, state=IDLE, stall_req_o=0.
  - After reset: div_ready_o=1, pend_o=0, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0.
- Effective pipeline write: pipe_act = pipe_we_i && (pipe_waddr_i != 0).
- Write-port mux (combinational, same cycle), in priority order:
  1. If pipe_act: the rf port carries the pipeline write.
  2. Else if buffer valid: the rf port carries the buffered entry (drain).
  3. Else if div_valid_i && div_waddr_i != 0: the rf port carries the divider result directly (bypass, zero latency, never buffered).
  4. Else: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0.
- div_ready_o = !buf_valid, a registered-state function only.
- Divider accept = div_valid_i && div_ready_o.
  - An accepted result with waddr 0 is consumed and discarded.
  - An accepted, nonzero result blocked by pipe_act is loaded into the buffer at the clock edge.
  - A divider result cannot be drained and accepted in the same cycle. Accept only when the buffer was empty.
- WAW kill: while the buffer is valid, if pipe_act && pipe_waddr_i == buf_waddr, the pipeline (younger) write proceeds. The buffer is invalidated at that edge without ever writing. Counter and state return to IDLE.
- pend_o = buf_valid. pend_waddr_o = buf_valid ? buf_waddr : 0.
- State machine:
  - IDLE (buffer empty): go to PEND on a buffer load; the counter is cleared.
  - PEND: each cycle the buffer is blocked (pipe_act), the counter increments.
    - When the counter reaches MAX_WAIT-1 while still blocked, go to FORCE.
    - On a drain or WAW kill, go to IDLE.
  - FORCE: stall_req_o=1, registered, asserted from the first cycle in FORCE.
    - Held until the drain or WAW kill edge, then go to IDLE. stall_req_o=0 the following cycle.
    - The counter saturates in FORCE; it does not wrap.
- Result: with continuous pipeline writes, stall_req_o rises exactly MAX_WAIT cycles after the buffer load.
- Reset mid-operation (PEND or FORCE) discards the buffered result. Recovery is the divider's responsibility.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> all outputs immediately at reset values, with div_ready_o=1. Hold 3 cycles and release -> no rf write.
- Bypass: pipe_we_i=0, div_valid_i=1, waddr=5, wdata=0x0000_1234 -> same cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x1234. Next cycle pend_o=0, div_ready_o=1.
- Conflict and drain: pipe_we_i=1 (waddr=3, data 0xAAAA_0000) and div result (waddr=7, data 0xBBBB_0001) in the same cycle -> rf writes r3 that cycle. Next cycle pend_o=1, pend_waddr_o=7, div_ready_o=0. Then pipe_we_i=0 -> rf writes r7=0xBBBB_0001; the following cycle pend_o=0 and div_ready_o=1.
- Starvation: MAX_WAIT=4, buffered write to r7, pipe_we_i=1 continuously to r1/r2 -> stall_req_o=1 on the 4th cycle after the load. Drop pipe_we_i for one cycle -> r7 drains and stall_req_o=0 next cycle.
- WAW kill and x0: buffered r7 then pipe write to r7 data 0x55 -> only 0x55 is written and the buffer clears without writing. Separately, divider result with waddr=0 while pipe is idle -> no rf_we_o and pend_o stays 0.
- Reset in FORCE: reach FORCE, then pulse rst_n -> stall_req_o=0 and pend_o=0 immediately; after release, r7 is never written.
